// File: rtl/cpu_mem_resp.sv
// Unified word-organised memory behind the core's fetch and data ports.
// Streams a program image in over a loader port and holds the core in reset until it is ready to run.
module cpu_mem_resp #(
    parameter int ADDR_WITDH  = 32,
    parameter int DATA_WITDH  = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int HOLD_CYCLES = 4,
    parameter int BYPASS_LOAD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WITDH-1:0] pc,
    output logic [DATA_WITDH-1:0] instr,
    input  logic [ADDR_WITDH-1:0] addr,
    input  logic [DATA_WITDH-1:0] wdata,
    input  logic [3:0]            wmask,
    input  logic                  we,
    output logic [DATA_WITDH-1:0] data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [DATA_WITDH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  cpu_rst,
    output logic                  err
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } state_t;

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DATA_WITDH-1:0] NOP_INSTR = DATA_WITDH'(32'h0000_0013);
    localparam state_t RESET_STATE = (BYPASS_LOAD != 0) ? ST_HOLD : ST_LOAD;

    logic [DATA_WITDH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [DEPTH_LOG2:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]     holdCnt_q, holdCnt_d;
    logic                  err_q, err_d;

    logic [DEPTH_LOG2-1:0] pcIdx, addrIdx, ptrIdx;
    logic                  pcInRange, addrInRange;
    logic                  running, lastSlot, ldFire, stFire;
    logic                  unusedAddrLsb;

    assign pcIdx         = pc[DEPTH_LOG2+1:2];
    assign addrIdx       = addr[DEPTH_LOG2+1:2];
    assign ptrIdx        = ptr_q[DEPTH_LOG2-1:0];
    assign pcInRange     = (pc >> (DEPTH_LOG2 + 2)) == '0;
    assign addrInRange   = (addr >> (DEPTH_LOG2 + 2)) == '0;
    assign unusedAddrLsb = ^addr[1:0];

    assign running  = (state_q == ST_RUN);
    assign lastSlot = (ptr_q == (DEPTH_LOG2+1)'(DEPTH - 1));
    // The array has no reset, so writes are gated by rst explicitly.
    assign ldFire   = (state_q == ST_LOAD) && ld_valid && !rst;
    assign stFire   = running && we && addrInRange && !rst;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        holdCnt_d = holdCnt_q;
        err_d     = err_q;
        case (state_q)
            ST_LOAD: begin
                if (ld_valid) begin
                    ptr_d = ptr_q + 1'b1;
                    if (ld_last || lastSlot) begin
                        state_d   = ST_HOLD;
                        holdCnt_d = HOLD_INIT;
                    end
                end
            end
            ST_HOLD: begin
                if (holdCnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    holdCnt_d = holdCnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if ((we && !addrInRange) || (pc[1:0] != 2'b00) || !pcInRange) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            ptr_q     <= '0;
            holdCnt_q <= HOLD_INIT;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            holdCnt_q <= holdCnt_d;
            err_q     <= err_d;
        end
    end

    // Loader and store never fire together: they are confined to different states.
    always_ff @(posedge clk) begin
        if (ldFire) begin
            mem[ptrIdx] <= ld_data;
        end else if (stFire) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[addrIdx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign instr    = running ? (pcInRange ? mem[pcIdx] : '0) : NOP_INSTR;
    assign data     = (running && addrInRange) ? mem[addrIdx] : '0;
    assign ld_ready = (state_q == ST_LOAD);
    assign cpu_rst  = !running;
    assign err      = err_q;

endmodule
